// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                op encodings, FSM state type and iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Encoding of the 2-bit op field presented by execute
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // One radix-2 iteration per operand bit
    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : Combinational single iteration of the radix-2 engine.
//                Multiply: shift-add, consumes acc[0] as the current
//                multiplier bit, adds the multiplicand into the upper half
//                and shifts the 64-bit accumulator right by one.
//                Divide: restoring step on {remainder, dividend}; shifts left,
//                trial-subtracts the divisor and shifts in a quotient bit.
//  Ports       : is_div   - 1 selects the divide step, 0 the multiply step
//                acc_in   - current 2*WIDTH accumulator
//                operand  - multiplicand (mul) or divisor (div)
//                acc_out  - accumulator after one iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                + (acc_in[0] ? {1'b0, operand} : '0);
        // Partial remainder shifted left by one, with the next dividend bit
        // appended; WIDTH+1 bits so the MSB of the difference is the borrow.
        w_trial = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

        if (is_div) begin
            if (!w_trial[WIDTH]) begin
                acc_out = {w_trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {w_sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO.
//                start latches operands (absolute values for signed ops),
//                32 CALC cycles run the radix-2 engine, one FIX cycle applies
//                sign correction and writes HI/LO. busy covers 33 cycles;
//                done pulses for the cycle after the HI/LO write.
//  Ports       : clock, reset (async, active-high)
//                start, op[1:0], operand_a, operand_b - operation request
//                mthi, mtlo, hilo_wdata               - direct HI/LO writes
//                busy, done, hi, lo                   - status and results
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [WIDTH-1:0]  hilo_wdata,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam logic [5:0] c_last_iter = 6'(MD_ITERS - 1);

    md_state_t          r_state;
    md_state_t          w_state_next;
    logic [5:0]         r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_is_div;
    logic               r_neg_main;   // negate product / quotient
    logic               r_neg_rem;    // negate remainder
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_start;
    logic               w_signed;
    logic               w_op_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // ------------------------------------------------------------------
    // Request decode and operand conditioning
    // ------------------------------------------------------------------
    always_comb begin
        w_start  = start && (r_state == IDLE);
        w_signed = (op == MD_MULT) || (op == MD_DIV);
        w_op_div = (op == MD_DIV) || (op == MD_DIVU);
        w_a_neg  = w_signed && operand_a[WIDTH-1];
        w_b_neg  = w_signed && operand_b[WIDTH-1];
        w_abs_a  = w_a_neg ? (~operand_a + 1'b1) : operand_a;
        w_abs_b  = w_b_neg ? (~operand_b + 1'b1) : operand_b;
    end

    muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .is_div  (r_is_div),
        .acc_in  (r_acc),
        .operand (r_opnd),
        .acc_out (w_step_acc)
    );

    // ------------------------------------------------------------------
    // Sign fix-up of the finished accumulator
    // ------------------------------------------------------------------
    always_comb begin
        w_prod = r_neg_main ? (~r_acc + 1'b1) : r_acc;
        w_quot = r_neg_main ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem  = r_neg_rem  ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                            : r_acc[2*WIDTH-1:WIDTH];

        if (!r_is_div) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (r_div_zero) begin
            // Divide by zero reports the raw dividend, not its magnitude
            w_res_hi = r_raw_a;
            w_res_lo = '1;
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = CALC;
            CALC:    if (r_count == c_last_iter) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counter and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_raw_a    <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_count    <= '0;
                        r_is_div   <= w_op_div;
                        r_raw_a    <= operand_a;
                        r_neg_main <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= w_op_div && (operand_b == '0);
                        if (w_op_div) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end else begin
                        // start takes priority: moves only when no op starts
                        if (mthi) r_hi <= hilo_wdata;
                        if (mtlo) r_lo <= hilo_wdata;
                    end
                end
                CALC: begin
                    r_acc   <= w_step_acc;
                    r_count <= r_count + 6'd1;
                end
                FIX: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : muldiv_unit
`default_nettype wire
